// File: rtl/spm_seq_ctrl_if.sv
// rtl/spm_seq_ctrl_if.sv - operand/product handshake bundle for the serial multiplier sequencer
interface spm_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, mc, mp, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, mc, mp, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - sequencer feeding a bit-serial signed multiplier array and collecting its product
module spm_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  spm_seq_ctrl_if.slave    bus,
  output logic             busy_o,
  output logic             spm_clr_o,
  output logic [WIDTH-1:0] spm_x_o,
  output logic             spm_y_o,
  input  logic             spm_p_i
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] ysh_q, ysh_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             clr_q, clr_d;
  logic             y_q, y_d;
  logic             run_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      ysh_q   <= '0;
      prod_q  <= '0;
      clr_q   <= 1'b1;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      ysh_q   <= ysh_d;
      prod_q  <= prod_d;
      clr_q   <= clr_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    ysh_d   = ysh_q;
    prod_d  = prod_q;
    y_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mc_d    = bus.mc;
          ysh_d   = bus.mp;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // The array lags one cycle, so cnt=0 carries no product bit yet.
        if (cnt_q != '0) begin
          prod_d = {spm_p_i, prod_q[PW-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // spm_y and spm_clr are registered, so they are computed for the upcoming cycle.
    run_next = (state_d == S_RUN);
    if (run_next && (cnt_d < CNT_LAST)) begin
      y_d   = ysh_q[0];
      ysh_d = {ysh_q[WIDTH-1], ysh_q[WIDTH-1:1]};
    end
    clr_d = !run_next;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = prod_q;
  assign busy_o        = (state_q != S_IDLE);
  assign spm_clr_o     = clr_q;
  assign spm_x_o       = mc_q;
  assign spm_y_o       = y_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb/tb_spm_seq_ctrl.sv - scoreboard bench for spm_seq_ctrl with a behavioural serial multiplier array
module tb_spm_seq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spm_seq_ctrl_if #(.WIDTH(W)) bus();

  logic         busy;
  logic         spm_clr;
  logic [W-1:0] spm_x;
  logic         spm_y;
  logic         spm_p;

  spm_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy_o    (busy),
    .spm_clr_o (spm_clr),
    .spm_x_o   (spm_x),
    .spm_y_o   (spm_y),
    .spm_p_i   (spm_p)
  );

  // Array: running sum of shifted multiplicand terms, emits bit k one cycle after term k.
  logic [2*W-1:0] arr_s, arr_next;
  logic [4:0]     arr_k;
  always_comb begin
    arr_next = arr_s;
    if (spm_y && arr_k < 5'(2*W))
      arr_next = arr_s + ({{W{spm_x[W-1]}}, spm_x} << arr_k);
  end
  always @(posedge clk) begin
    if (spm_clr) begin
      arr_s <= '0;
      arr_k <= '0;
      spm_p <= 1'b0;
    end else if (arr_k < 5'(2*W)) begin
      arr_s <= arr_next;
      spm_p <= arr_next[arr_k[3:0]];
      arr_k <= arr_k + 5'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [2*W-1:0] last_prod;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb);
    int t;
    int acc;
    logic [2*W-1:0] e;
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.mc        = a;
    bus.mp        = b;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: in_ready=%b required 1", bus.in_ready);
    end
    e = $signed(a) * $signed(b);
    exp_q.push_back(e);
    acc = cyc + 1;
    last_acc = acc;
    @(negedge clk);
    bus.mc = na;
    bus.mp = nb;
    if (!hold) bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cyc - acc !== 18) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 18", cyc - acc);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1 || bus.product !== exp_q[0]) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%b in_ready=%b busy=%b product=%h required 1 0 1 %h",
                 bus.out_valid, bus.in_ready, busy, bus.product, exp_q[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    e = exp_q.pop_front();
    last_prod = bus.product;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product !== e) begin
      errors++;
      $display("FAIL product: a=%h b=%h out_valid=%b product=%h required 1 %h",
               a, b, bus.out_valid, bus.product, e);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.product !== e) begin
      errors++;
      $display("FAIL idle_after: out_valid=%b in_ready=%b busy=%b product=%h required 0 1 0 %h",
               bus.out_valid, bus.in_ready, busy, bus.product, e);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, spm_clr, spm_y, bus.product, spm_x} !== {5'b10010, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy/clr/y=%b%b%b%b%b product=%h x=%h required 10010 0000 00",
               bus.in_ready, bus.out_valid, busy, spm_clr, spm_y, bus.product, spm_x);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || spm_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b spm_clr=%b busy=%b required 1 1 0", bus.in_ready, spm_clr, busy);
    end
  endtask

  task automatic test_basic();
    run_job(8'd50, 8'hCE, 0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (last_prod !== 16'hF63C) begin
      errors++;
      $display("FAIL basic_const: product=%h required f63c", last_prod);
    end
  endtask

  task automatic test_extremes();
    run_job(8'h80, 8'h80, 0, 1'b0, 8'h11, 8'h22);
    checks++;
    if (last_prod !== 16'h4000) begin
      errors++;
      $display("FAIL extreme_min: product=%h required 4000", last_prod);
    end
    run_job(8'h7F, 8'h80, 0, 1'b0, 8'h33, 8'h44);
    checks++;
    if (last_prod !== 16'hC080) begin
      errors++;
      $display("FAIL extreme_mix: product=%h required c080", last_prod);
    end
    run_job(8'h00, 8'h5A, 0, 1'b0, 8'h55, 8'h66);
  endtask

  task automatic test_back_to_back();
    int first_acc;
    run_job(8'd3, 8'd5, 0, 1'b1, 8'hFF, 8'hFF);
    first_acc = last_acc;
    run_job(8'hFF, 8'hFF, 0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (last_prod !== 16'h0001 || last_acc - first_acc !== 20) begin
      errors++;
      $display("FAIL back_to_back: product=%h spacing=%0d required 0001 20", last_prod, last_acc - first_acc);
    end
  endtask

  task automatic test_stall();
    run_job(8'hE7, 8'h13, 10, 1'b0, 8'hA5, 8'h5A);
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.mc        = 8'h07;
    bus.mp        = 8'h11;
    exp_q.push_back(16'h0077);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || spm_clr !== 1'b0) begin
      errors++;
      $display("FAIL mid_run: busy=%b spm_clr=%b required 1 0", busy, spm_clr);
    end
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, spm_clr, spm_y, bus.product, spm_x} !== {5'b10010, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL mid_reset: rdy/vld/busy/clr/y=%b%b%b%b%b product=%h x=%h required 10010 0000 00",
               bus.in_ready, bus.out_valid, busy, spm_clr, spm_y, bus.product, spm_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(8'd7, 8'hFD, 2, 1'b0, 8'h00, 8'h00);
    checks++;
    if (last_prod !== 16'hFFEB) begin
      errors++;
      $display("FAIL after_reset: product=%h required ffeb", last_prod);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_job(W'($urandom), W'($urandom), st, 1'b0, W'($urandom), W'($urandom));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mc        = '0;
    bus.mp        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
